// File: rtl/instr_fetch.sv
// Instruction fetch front-end: follows the core PC, prefetches sequential words
// into a small FIFO and serves hits combinationally, with a bypass on the ack cycle.
module instr_fetch #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        ifValid,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memRdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Memory handshake: memReq/memAddr are registered and held stable until memAck;
  // memAck is only meaningful while memReq=1, and completes the request that cycle.

  // FIFO entries are address-consecutive, so only the head address is stored.
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   head_q, head_d;

  // Outstanding request slot.
  logic          busy_q, busy_d;
  logic          stale_q, stale_d;
  logic [31:0]   addr_q, addr_d;

  logic [31:0]   pc_w;
  logic [31:0]   diff;
  logic [31:0]   hit_off;
  logic          hit;
  logic [AW-1:0] hit_idx;
  logic [AW-1:0] rd_idx;
  logic          ack;
  logic          inflight_pc;
  logic          redirect;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] cnt_u;
  logic [31:0]   tail_addr;
  logic          unused_bits;

  assign pc_w        = {pc[31:2], 2'b00};
  assign diff        = pc_w - head_q;
  assign hit_off     = {2'b00, diff[31:2]};
  assign hit         = hit_off < 32'(cnt_q);
  assign hit_idx     = hit_off[AW-1:0];
  assign rd_idx      = rd_q + hit_idx;
  assign ack         = memAck & busy_q;
  assign inflight_pc = busy_q & ~stale_q & (addr_q == pc_w);
  assign redirect    = ~hit & ~inflight_pc;
  assign unused_bits = ^{pc[1:0], diff[1:0]};

  assign memReq  = busy_q;
  assign memAddr = addr_q;

  always_comb begin
    ifValid = 1'b0;
    instr   = NOP;
    if (hit) begin
      ifValid = 1'b1;
      instr   = data_q[rd_idx];
    end else if (ack && inflight_pc) begin
      ifValid = 1'b1;
      instr   = memRdata;
    end
  end

  always_comb begin
    rd_d      = rd_q;
    cnt_u     = cnt_q;
    head_d    = head_q;
    wr_en     = 1'b0;
    busy_d    = busy_q;
    stale_d   = stale_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tail_addr = head_q;

    // Hit keeps the matching entry: the core may hold pc for several cycles.
    if (hit) begin
      rd_d   = rd_idx;
      cnt_u  = cnt_q - CW'(hit_idx);
      head_d = pc_w;
    end else begin
      cnt_u  = '0;
    end

    // An ack landing in a redirect cycle belongs to the abandoned path.
    if (ack) begin
      busy_d  = 1'b0;
      stale_d = 1'b0;
      wr_en   = ~stale_q & ~redirect;
    end else if (busy_q && redirect) begin
      stale_d = 1'b1;
    end

    if (wr_en && (cnt_u == '0)) begin
      head_d = addr_q;
    end
    cnt_d     = cnt_u + CW'(wr_en);
    tail_addr = head_d + {{(30 - CW){1'b0}}, cnt_d, 2'b00};

    if (!busy_d && (cnt_d < CW'(DEPTH))) begin
      busy_d  = 1'b1;
      stale_d = 1'b0;
      addr_d  = (cnt_d == '0) ? pc_w : tail_addr;
    end
  end

  assign wr_idx = rd_d + cnt_u[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      busy_q  <= 1'b0;
      stale_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      busy_q  <= busy_d;
      stale_q <= stale_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= memRdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_instr_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        ifValid;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck = 1'b0;
  logic [31:0] memRdata = '0;

  instr_fetch #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .instr    (instr),
    .ifValid  (ifValid),
    .memReq   (memReq),
    .memAddr  (memAddr),
    .memAck   (memAck),
    .memRdata (memRdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  // ---------------- memory responder ----------------
  int          mem_lat = 1;
  int          mcnt = 0;
  logic [31:0] ack_log[$];

  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      mcnt     = 0;
      memAck   = 1'b0;
      memRdata = 32'hBAD0BAD0;
    end else if (memReq) begin
      mcnt++;
      if (mcnt >= mem_lat) begin
        memAck   = 1'b1;
        memRdata = mem_fn(memAddr);
        mcnt     = 0;
        ack_log.push_back(memAddr);
      end else begin
        memAck   = 1'b0;
        memRdata = 32'hBAD0BAD0;
      end
    end else begin
      mcnt     = 0;
      memAck   = 1'b0;
      memRdata = 32'hBAD0BAD0;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_addr = '0;
  logic        watch_bad = 1'b0;
  int          bad_seen = 0;

  always @(negedge clk) begin
    logic [31:0] pcw;
    logic [31:0] exp_i;
    logic        exp_v;
    logic        ack_ok;
    logic        redir;
    int          hit_i;
    if (rst) begin
      mq.delete();
      m_busy  = 1'b0;
      m_stale = 1'b0;
      m_addr  = '0;
      chk("rst_memReq", 32'(memReq), 32'd0);
      chk("rst_memAddr", memAddr, 32'd0);
      chk("rst_ifValid", 32'(ifValid), 32'd0);
      chk("rst_instr", instr, NOP);
    end else begin
      pcw   = {pc[31:2], 2'b00};
      hit_i = -1;
      foreach (mq[i]) if (hit_i < 0 && mq[i].addr == pcw) hit_i = i;
      ack_ok = memAck && m_busy;
      if (hit_i >= 0) begin
        exp_v = 1'b1;
        exp_i = mq[hit_i].data;
      end else if (ack_ok && !m_stale && m_addr == pcw) begin
        exp_v = 1'b1;
        exp_i = memRdata;
      end else begin
        exp_v = 1'b0;
        exp_i = NOP;
      end
      chk("ifValid", 32'(ifValid), 32'(exp_v));
      chk("instr", instr, exp_i);
      chk("memReq", 32'(memReq), 32'(m_busy));
      if (m_busy) chk("memAddr", memAddr, m_addr);
      if (watch_bad && ifValid && instr == 32'hC0DE0018) bad_seen++;

      // state after the coming edge
      redir = 1'b0;
      if (hit_i >= 0) begin
        repeat (hit_i) void'(mq.pop_front());
      end else begin
        if (!(m_busy && !m_stale && m_addr == pcw)) redir = 1'b1;
        mq.delete();
      end
      if (ack_ok) begin
        if (!m_stale && !redir) mq.push_back({m_addr, memRdata});
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (redir && m_busy) begin
        m_stale = 1'b1;
      end
      if (!m_busy && mq.size() < DEPTH) begin
        m_addr  = (mq.size() == 0) ? pcw : mq[mq.size()-1].addr + 32'd4;
        m_busy  = 1'b1;
        m_stale = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [31:0] new_pc, input int lat);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    pc      = new_pc;
    mem_lat = lat;
    ack_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Core model: advance pc by 4 after every cycle ifValid=1, stop at 'last'.
  task automatic run_seq(input logic [31:0] last, input int budget,
                         output int bubbles, output logic done);
    logic v;
    logic started;
    started = 1'b0;
    bubbles = 0;
    done    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      v = ifValid;
      if (v) started = 1'b1;
      else if (started) bubbles++;
      @(posedge clk);
      #1;
      if (v && pc == last) begin
        done = 1'b1;
        break;
      end
      if (v) pc = pc + 32'd4;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int   bub;
    logic done;
    logic found;

    // Straight-line code from 0x0 with a 1-cycle memory
    do_reset(32'h0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("first_memReq", 32'(memReq), 32'd1);
    chk("first_memAddr", memAddr, 32'h0);
    chk("first_ifValid", 32'(ifValid), 32'd1);
    chk("first_instr", instr, 32'hC0DE0000);
    run_seq(32'h44, 100, bub, done);
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_bubbles", 32'(bub), 32'd0);
    @(negedge clk);
    chk("seq_instr44", instr, 32'hC0DE0044);

    // Core stall at 0x8: buffer fills, memReq drops
    do_reset(32'h0, 1);
    run_seq(32'h8, 50, bub, done);
    chk("stall_reach", 32'(done), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ifValid", 32'(ifValid), 32'd1);
      chk("stall_instr", instr, 32'hC0DE0008);
    end
    chk("stall_full_memReq", 32'(memReq), 32'd0);
    @(posedge clk);
    #1;
    pc = 32'h0000000B;
    @(negedge clk);
    chk("lowbits_ifValid", 32'(ifValid), 32'd1);
    chk("lowbits_instr", instr, 32'hC0DE0008);
    @(posedge clk);
    #1;
    pc = 32'h0000000C;
    @(negedge clk);
    chk("advance_ifValid", 32'(ifValid), 32'd1);
    chk("advance_instr", instr, 32'hC0DE000C);
    run_seq(32'h20, 60, bub, done);
    chk("stall_resume_done", 32'(done), 32'd1);
    chk("stall_resume_bubbles", 32'(bub), 32'd0);

    // Redirect 0x10 -> 0x100 while the 0x18 request is outstanding
    do_reset(32'h10, 3);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (memReq && memAddr == 32'h18) begin
        found = 1'b1;
        break;
      end
    end
    chk("redir_req18_seen", 32'(found), 32'd1);
    pc        = 32'h100;
    watch_bad = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (memReq && memAddr == 32'h100) begin
        found = 1'b1;
        break;
      end
    end
    chk("redir_req100_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifValid) begin
        found = 1'b1;
        break;
      end
    end
    chk("redir_valid_seen", 32'(found), 32'd1);
    chk("redir_instr", instr, 32'hC0DE0100);
    watch_bad = 1'b0;
    chk("redir_stale_shown", 32'(bad_seen), 32'd0);
    chk("redir_log_len", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      chk("redir_log2", ack_log[2], 32'h18);
      chk("redir_log3", ack_log[3], 32'h100);
    end

    // Slow memory: 4-cycle ack latency
    do_reset(32'h200, 4);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n >= 2) begin
        chk("slow_memReq", 32'(memReq), 32'd1);
        chk("slow_memAddr", memAddr, 32'h200);
        chk("slow_ifValid", 32'(ifValid), (n == 5) ? 32'd1 : 32'd0);
      end
    end
    chk("slow_instr", instr, 32'hC0DE0200);

    // Asynchronous reset with full buffer and a request in flight
    do_reset(32'h300, 4);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (memReq && memAddr == 32'h30C) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst_full_seen", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_memReq", 32'(memReq), 32'd0);
    chk("midrst_ifValid", 32'(ifValid), 32'd0);
    chk("midrst_instr", instr, 32'h00000013);
    pc = 32'h500;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_first_memReq", 32'(memReq), 32'd1);
    chk("midrst_first_memAddr", memAddr, 32'h500);

    // Address wrap from 0xFFFFFFF8
    do_reset(32'hFFFFFFF8, 1);
    run_seq(32'hFFFFFFFC, 50, bub, done);
    chk("wrap_reach_fc", 32'(done), 32'd1);
    @(negedge clk);
    chk("wrap_instr_fc", instr, 32'h3F21FFFC);
    run_seq(32'h0, 50, bub, done);
    chk("wrap_reach_0", 32'(done), 32'd1);
    @(negedge clk);
    chk("wrap_instr_0", instr, 32'hC0DE0000);
    run_seq(32'h8, 50, bub, done);
    chk("wrap_reach_8", 32'(done), 32'd1);
    chk("wrap_log_len_ok", 32'(ack_log.size() >= 3), 32'd1);
    if (ack_log.size() >= 3) begin
      chk("wrap_log0", ack_log[0], 32'hFFFFFFF8);
      chk("wrap_log1", ack_log[1], 32'hFFFFFFFC);
      chk("wrap_log2", ack_log[2], 32'h00000000);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
